// File: rtl/hyperbus_phy_ctrl.sv
// HyperBus transaction engine: turns single 16-bit read/write requests into
// CS#/CA/latency/data/recovery sequences on registered HyperBus pin outputs.
module hyperbus_phy_ctrl #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int LATENCY         = 6,
    parameter int TRWR            = 4,
    parameter int RD_TIMEOUT      = 64
) (
    input  logic                       hbus_clk,
    input  logic                       hbus_rst_n,
    input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    input  logic                       hbus_rrq,
    input  logic                       hbus_wrq,
    output logic                       hbus_ready,
    output logic                       hbus_valid,
    output logic                       hbus_busy,
    output logic                       hbus_err,
    output logic                       hb_cs_n,
    output logic                       hb_ck,
    output logic [7:0]                 hb_dq_o,
    output logic                       hb_dq_oe,
    input  logic [7:0]                 hb_dq_i,
    output logic                       hb_rwds_o,
    output logic                       hb_rwds_oe,
    input  logic                       hb_rwds_i
);

    typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_WDATA, S_RDATA, S_RECOV} state_t;

    localparam logic [15:0] LAT_1X  = 16'(2 * LATENCY - 4);
    localparam logic [15:0] LAT_2X  = 16'(4 * LATENCY - 4);
    localparam logic [15:0] TRWR_M1 = 16'(TRWR - 1);
    localparam logic [15:0] RD_TO   = 16'(RD_TIMEOUT);

    function automatic logic [47:0] ca_word(input logic rd, input logic [31:0] wa);
        ca_word = {rd, 1'b0, 1'b1, wa[31:3], 13'd0, wa[2:0]};
    endfunction

    state_t                     state_q, state_d;
    logic [15:0]                cnt_q, cnt_d;
    logic [HBUS_ADDR_WIDTH-2:0] wadr_q, wadr_d;
    logic [HBUS_DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic                       rd_q, rd_d;
    logic                       lat2x_q, lat2x_d;
    logic                       rwds_prev_q, rwds_prev_d;
    logic [7:0]                 byte_hi_q, byte_hi_d;
    logic                       got_hi_q, got_hi_d;
    logic                       cs_n_q, cs_n_d;
    logic                       ck_q, ck_d;
    logic [7:0]                 dq_o_q, dq_o_d;
    logic                       dq_oe_q, dq_oe_d;
    logic                       rwds_o_q, rwds_o_d;
    logic                       rwds_oe_q, rwds_oe_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       valid_q, valid_d;
    logic                       err_q, err_d;
    logic [HBUS_DATA_WIDTH-1:0] dat_o_q, dat_o_d;

    logic [31:0] wa_s;
    logic [47:0] ca_s;
    logic [7:0]  ca_byte_s;
    logic [15:0] lat_len_s;
    logic        accept_s;
    logic        rwds_edge_s;
    logic        unused_s;

    assign unused_s = hbus_adr_i[0];

    // CA word for the latched request and the byte selected by the phase counter
    always_comb begin
        wa_s      = 32'(wadr_q);
        ca_s      = ca_word(rd_q, wa_s);
        ca_byte_s = 8'd0;
        case (cnt_q[2:0])
            3'd0:    ca_byte_s = ca_s[47:40];
            3'd1:    ca_byte_s = ca_s[39:32];
            3'd2:    ca_byte_s = ca_s[31:24];
            3'd3:    ca_byte_s = ca_s[23:16];
            3'd4:    ca_byte_s = ca_s[15:8];
            3'd5:    ca_byte_s = ca_s[7:0];
            default: ca_byte_s = 8'd0;
        endcase
    end

    assign lat_len_s   = lat2x_q ? LAT_2X : LAT_1X;
    assign accept_s    = (hbus_rrq | hbus_wrq) & ready_q;
    assign rwds_edge_s = hb_rwds_i ^ rwds_prev_q;

    // Next-state and next-output logic; pin outputs lag the state by one cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        wadr_d      = wadr_q;
        wdat_d      = wdat_q;
        rd_d        = rd_q;
        lat2x_d     = lat2x_q;
        rwds_prev_d = hb_rwds_i;
        byte_hi_d   = byte_hi_q;
        got_hi_d    = got_hi_q;
        cs_n_d      = 1'b1;
        ck_d        = 1'b0;
        dq_o_d      = 8'd0;
        dq_oe_d     = 1'b0;
        rwds_o_d    = 1'b0;
        rwds_oe_d   = 1'b0;
        ready_d     = 1'b0;
        busy_d      = 1'b1;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        dat_o_d     = dat_o_q;
        case (state_q)
            S_IDLE: begin
                cnt_d    = 16'd0;
                got_hi_d = 1'b0;
                if (accept_s) begin
                    wadr_d  = hbus_adr_i[HBUS_ADDR_WIDTH-1:1];
                    wdat_d  = hbus_dat_i;
                    rd_d    = hbus_rrq;
                    state_d = S_CA;
                end else begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_CA: begin
                cs_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                dq_o_d  = ca_byte_s;
                ck_d    = (cnt_q == 16'd0) ? 1'b0 : ~ck_q;
                // cnt 3 is the cycle in which CA byte 2 is on the pins
                if (cnt_q == 16'd3) begin
                    lat2x_d = hb_rwds_i;
                end else begin
                    lat2x_d = lat2x_q;
                end
                if (cnt_q == 16'd5) begin
                    state_d = S_LAT;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = S_CA;
                end
            end
            S_LAT: begin
                cs_n_d = 1'b0;
                ck_d   = ~ck_q;
                if (cnt_q == lat_len_s - 16'd1) begin
                    state_d = rd_q ? S_RDATA : S_WDATA;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = S_LAT;
                end
            end
            S_WDATA: begin
                cs_n_d    = 1'b0;
                ck_d      = ~ck_q;
                dq_oe_d   = 1'b1;
                rwds_oe_d = 1'b1;
                if (cnt_q == 16'd0) begin
                    dq_o_d  = wdat_q[15:8];
                    state_d = S_WDATA;
                end else begin
                    dq_o_d  = wdat_q[7:0];
                    state_d = S_RECOV;
                    cnt_d   = 16'd0;
                end
            end
            S_RDATA: begin
                cs_n_d = 1'b0;
                ck_d   = ~ck_q;
                if (rwds_edge_s && got_hi_q) begin
                    dat_o_d = {byte_hi_q, hb_dq_i};
                    valid_d = 1'b1;
                    state_d = S_RECOV;
                    cnt_d   = 16'd0;
                end else if (cnt_q >= RD_TO) begin
                    err_d   = 1'b1;
                    state_d = S_RECOV;
                    cnt_d   = 16'd0;
                end else if (rwds_edge_s) begin
                    byte_hi_d = hb_dq_i;
                    got_hi_d  = 1'b1;
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_RECOV: begin
                if (cnt_q == TRWR_M1) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = S_RECOV;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // State, datapath and registered output flops
    always_ff @(posedge hbus_clk or negedge hbus_rst_n) begin
        if (!hbus_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            wadr_q      <= '0;
            wdat_q      <= '0;
            rd_q        <= 1'b0;
            lat2x_q     <= 1'b0;
            rwds_prev_q <= 1'b0;
            byte_hi_q   <= 8'd0;
            got_hi_q    <= 1'b0;
            cs_n_q      <= 1'b1;
            ck_q        <= 1'b0;
            dq_o_q      <= 8'd0;
            dq_oe_q     <= 1'b0;
            rwds_o_q    <= 1'b0;
            rwds_oe_q   <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            dat_o_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wadr_q      <= wadr_d;
            wdat_q      <= wdat_d;
            rd_q        <= rd_d;
            lat2x_q     <= lat2x_d;
            rwds_prev_q <= rwds_prev_d;
            byte_hi_q   <= byte_hi_d;
            got_hi_q    <= got_hi_d;
            cs_n_q      <= cs_n_d;
            ck_q        <= ck_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            rwds_o_q    <= rwds_o_d;
            rwds_oe_q   <= rwds_oe_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            dat_o_q     <= dat_o_d;
        end
    end

    assign hb_cs_n    = cs_n_q;
    assign hb_ck      = ck_q;
    assign hb_dq_o    = dq_o_q;
    assign hb_dq_oe   = dq_oe_q;
    assign hb_rwds_o  = rwds_o_q;
    assign hb_rwds_oe = rwds_oe_q;
    assign hbus_ready = ready_q;
    assign hbus_busy  = busy_q;
    assign hbus_valid = valid_q;
    assign hbus_err   = err_q;
    assign hbus_dat_o = dat_o_q;

endmodule

// File: tb/tb_hyperbus_phy_ctrl.sv
// Bench for hyperbus_phy_ctrl: a table of directed and random transactions, each
// checked cycle by cycle against a phase-timeline model of the HyperBus pins.
module tb_hyperbus_phy_ctrl;

    localparam int LATENCY    = 6;
    localparam int TRWR       = 4;
    localparam int RD_TIMEOUT = 64;

    logic        hbus_clk = 1'b0;
    logic        hbus_rst_n = 1'b0;
    logic [31:0] hbus_adr_i = 32'd0;
    logic [15:0] hbus_dat_i = 16'd0;
    logic [15:0] hbus_dat_o;
    logic        hbus_rrq = 1'b0;
    logic        hbus_wrq = 1'b0;
    logic        hbus_ready, hbus_valid, hbus_busy, hbus_err;
    logic        hb_cs_n, hb_ck, hb_dq_oe, hb_rwds_o, hb_rwds_oe;
    logic [7:0]  hb_dq_o;
    logic [7:0]  hb_dq_i = 8'd0;
    logic        hb_rwds_i = 1'b0;

    hyperbus_phy_ctrl #(
        .HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16), .LATENCY(LATENCY),
        .TRWR(TRWR), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .hbus_clk(hbus_clk), .hbus_rst_n(hbus_rst_n),
        .hbus_adr_i(hbus_adr_i), .hbus_dat_i(hbus_dat_i), .hbus_dat_o(hbus_dat_o),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_ready(hbus_ready),
        .hbus_valid(hbus_valid), .hbus_busy(hbus_busy), .hbus_err(hbus_err),
        .hb_cs_n(hb_cs_n), .hb_ck(hb_ck), .hb_dq_o(hb_dq_o), .hb_dq_oe(hb_dq_oe),
        .hb_dq_i(hb_dq_i), .hb_rwds_o(hb_rwds_o), .hb_rwds_oe(hb_rwds_oe),
        .hb_rwds_i(hb_rwds_i)
    );

    always #5 hbus_clk = ~hbus_clk;

    typedef struct {
        bit          rd;
        bit          wr;
        bit          hold_wr;
        logic [31:0] adr;
        logic [15:0] wdat;
        bit          lat2x;
        int          d1;
        int          d2;
        bit          tmo;
        logic [15:0] rdata;
        logic [47:0] exp_ca;
        int          exp_lat;
    } vec_t;

    typedef struct packed {
        logic        cs_n;
        logic        ck;
        logic        dq_oe;
        logic [7:0]  dq;
        logic        rwds_oe;
        logic        rwds_o;
        logic        ready;
        logic        busy;
        logic        valid;
        logic        err;
        logic [15:0] dat;
    } obs_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_dat = 16'd0;
    vec_t        tbl[$];

    function automatic obs_t sample();
        obs_t o;
        o.cs_n    = hb_cs_n;
        o.ck      = hb_ck;
        o.dq_oe   = hb_dq_oe;
        o.dq      = hb_dq_oe ? hb_dq_o : 8'd0;
        o.rwds_oe = hb_rwds_oe;
        o.rwds_o  = hb_rwds_oe ? hb_rwds_o : 1'b0;
        o.ready   = hbus_ready;
        o.busy    = hbus_busy;
        o.valid   = hbus_valid;
        o.err     = hbus_err;
        o.dat     = hbus_dat_o;
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o       = '0;
        o.cs_n  = 1'b1;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic logic [47:0] model_ca(input bit rd, input logic [31:0] adr);
        longint unsigned wa, ca;
        wa = longint'(adr) / 2;
        ca = (longint'(rd) << 47) + (64'd1 << 45) + ((wa / 8) << 16) + (wa % 8);
        return ca[47:0];
    endfunction

    function automatic int model_lat(input bit lat2x);
        return 2 * LATENCY * (lat2x ? 2 : 1) - 4;
    endfunction

    function automatic int data_len(input vec_t v);
        if (!v.rd) return 2;
        if (v.tmo) return RD_TIMEOUT + 1;
        return v.d2 + 2;
    endfunction

    // k = cycles after the accepting clock edge
    function automatic obs_t model(input vec_t v, input int k, input logic [15:0] prev);
        obs_t e;
        int   L, D;
        L     = v.exp_lat;
        D     = data_len(v);
        e     = '0;
        e.cs_n = 1'b1;
        e.dat  = prev;
        if (k >= 1 && k <= 6 + L + D) begin
            e.cs_n = 1'b0;
            e.ck   = 1'((k - 1) % 2);
        end
        if (k >= 1 && k <= 6) begin
            e.dq_oe = 1'b1;
            e.dq    = 8'(v.exp_ca >> (8 * (6 - k)));
        end
        if (!v.rd && (k == 7 + L || k == 8 + L)) begin
            e.dq_oe   = 1'b1;
            e.rwds_oe = 1'b1;
            e.dq      = (k == 7 + L) ? v.wdat[15:8] : v.wdat[7:0];
        end
        if (v.rd && k == 6 + L + D) begin
            e.err   = v.tmo;
            e.valid = !v.tmo;
        end
        if (v.rd && !v.tmo && k >= 6 + L + D) e.dat = v.rdata;
        e.ready = (k >= 7 + L + D + TRWR);
        e.busy  = !e.ready;
        return e;
    endfunction

    function automatic vec_t mk(input bit rd, input bit wr, input bit hold,
                                input logic [31:0] adr, input logic [15:0] wd,
                                input bit l2, input int d1, input int d2, input bit tmo,
                                input logic [15:0] rdat, input logic [47:0] ca, input int lat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.hold_wr = hold; v.adr = adr; v.wdat = wd;
        v.lat2x = l2; v.d1 = d1; v.d2 = d2; v.tmo = tmo; v.rdata = rdat;
        v.exp_ca = ca; v.exp_lat = lat;
        return v;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic run_txn(input int id, input vec_t v);
        int   w, L, kend;
        obs_t got, exp;
        hbus_adr_i = v.adr;
        hbus_dat_i = v.wdat;
        hbus_rrq   = v.rd;
        hbus_wrq   = v.wr;
        w = 0;
        while (hbus_ready !== 1'b1 && w < 100) begin
            @(posedge hbus_clk); #1;
            w++;
        end
        checks++;
        if (hbus_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept txn %0d: ready=%b after %0d cycles, want 1", id, hbus_ready, w);
            hbus_rrq = 1'b0;
            hbus_wrq = 1'b0;
            return;
        end
        L    = v.exp_lat;
        kend = 7 + L + data_len(v) + TRWR;
        @(posedge hbus_clk); #1;
        for (int k = 0; k <= kend; k++) begin
            got = sample();
            exp = model(v, k, last_dat);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pins txn %0d cyc %0d: got %h want %h", id, k, got, exp);
            end
            if (k == kend) break;
            if (k == 0) begin
                hbus_rrq = 1'b0;
                hbus_wrq = v.hold_wr;
            end
            if (k >= 1 && k <= 6) hb_rwds_i = v.lat2x;
            else if (k == 7) hb_rwds_i = 1'b0;
            if (v.rd && !v.tmo && k == 7 + L + v.d1) begin
                hb_rwds_i = ~hb_rwds_i;
                hb_dq_i   = v.rdata[15:8];
            end else if (v.rd && !v.tmo && k == 7 + L + v.d2) begin
                hb_rwds_i = ~hb_rwds_i;
                hb_dq_i   = v.rdata[7:0];
            end else begin
                hb_dq_i = 8'($urandom);
            end
            @(posedge hbus_clk); #1;
        end
        if (v.rd && !v.tmo) last_dat = v.rdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        repeat (3) @(posedge hbus_clk);
        #1;
        check_obs("reset_hold", sample(), reset_obs());
        hbus_rst_n = 1'b1;
        @(posedge hbus_clk); #1;
        check_obs("idle_after_reset", sample(), reset_obs());

        // Reset pulsed while the engine sits in the latency phase
        hbus_adr_i = 32'h40;
        hbus_dat_i = 16'h1111;
        hbus_wrq   = 1'b1;
        @(posedge hbus_clk); #1;
        hbus_wrq = 1'b0;
        repeat (10) @(posedge hbus_clk);
        #1;
        checks++;
        if (hb_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL lat_cs_low: cs_n=%b want 0", hb_cs_n);
        end
        #2 hbus_rst_n = 1'b0;
        #1 check_obs("async_reset", sample(), reset_obs());
        @(posedge hbus_clk); #1;
        hbus_rst_n = 1'b1;
        @(posedge hbus_clk); #1;
        check_obs("post_reset_idle", sample(), reset_obs());
        last_dat = 16'd0;

        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_1234, 16'hA55A, 1'b0, 0, 0, 1'b0, 16'h0000, 48'h2000_0123_0002, 8));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_1234, 16'hA55A, 1'b1, 0, 0, 1'b0, 16'h0000, 48'h2000_0123_0002, 20));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0010, 16'h0000, 1'b0, 0, 1, 1'b0, 16'hBEEF, 48'hA000_0001_0000, 8));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0010, 16'h0000, 1'b0, 0, 0, 1'b1, 16'h0000, 48'hA000_0001_0000, 8));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 32'h0000_2468, 16'h1357, 1'b0, 2, 5, 1'b0, 16'hC0DE, 48'hA000_0246_0004, 8));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_2468, 16'h1357, 1'b0, 0, 0, 1'b0, 16'h0000, 48'h2000_0246_0004, 8));
        for (int i = 0; i < 20; i++) begin
            v.rd      = 1'($urandom);
            v.wr      = !v.rd;
            v.hold_wr = 1'b0;
            v.adr     = $urandom;
            v.wdat    = 16'($urandom);
            v.lat2x   = 1'($urandom);
            v.d1      = int'($urandom_range(0, 3));
            v.d2      = v.d1 + 1 + int'($urandom_range(0, 3));
            v.tmo     = v.rd && ($urandom_range(0, 7) == 0);
            v.rdata   = 16'($urandom);
            v.exp_ca  = model_ca(v.rd, v.adr);
            v.exp_lat = model_lat(v.lat2x);
            tbl.push_back(v);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            run_txn(i, tbl[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
